id_exe_stage: RTL and testbench
===============================

Name: id_exe_stage

Overview:
- ID/EXE pipeline register plus operand-select logic sitting directly upstream of the ALU in the 5-stage MIPS core.
- Captures decoded fields from ID each cycle, honours stall and flush, and forwards results from the MEM and WB stages.
- Drives the ALU's A, B and 4-bit CMD, and passes control and destination fields downstream.
- Detects load-use hazards and raises a stall request back to the fetch and decode stages.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- stall  in  1  hold the ID/EXE register contents.
- flush  in  1  insert a bubble into the ID/EXE register.
- id_pc  in  DW  PC of the instruction in ID.
- id_val1  in  DW  register-file rs value.
- id_val2  in  DW  register-file rt value.
- id_imm  in  DW  sign- or zero-extended immediate (shamt for shifts).
- id_src1  in  RW  rs index.
- id_src2  in  RW  rt index.
- id_dest  in  RW  destination index.
- id_cmd  in  4  ALU command.
- id_imm_sel  in  1  1 selects the immediate for B.
- id_mem_r_en  in  1  load.
- id_mem_w_en  in  1  store.
- id_wb_en  in  1  register write.
- mem_dest  in  RW  destination in MEM.
- mem_wb_en  in  1  MEM writes a register.
- mem_res  in  DW  ALU result in MEM.
- wb_dest  in  RW  destination in WB.
- wb_wb_en  in  1  WB writes a register.
- wb_value  in  DW  writeback value.
- alu_a  out  DW  ALU operand A.
- alu_b  out  DW  ALU operand B.
- alu_cmd  out  4  ALU CMD.
- exe_st_val  out  DW  forwarded rt value for stores.
- exe_pc  out  DW  registered PC.
- exe_dest  out  RW  registered destination.
- exe_mem_r_en  out  1  registered load control.
- exe_mem_w_en  out  1  registered store control.
- exe_wb_en  out  1  registered writeback control.
- exe_valid  out  1  slot holds a real instruction.
- hazard_stall  out  1  load-use stall request.

Behaviour:
- Reset (rst=0, asynchronous): all registered fields are 0, so exe_valid=0 and all enables are 0. alu_cmd=0000 (ADD), alu_a=alu_b=0, hazard_stall=0.
- Each rising edge, priority is rst > flush > stall > load:
  - flush: clears valid, mem_r_en, mem_w_en and wb_en; data fields may hold any value.
  - stall: retains all fields.
  - otherwise: captures every id_* input and sets valid=1.
- flush and stall asserted together: flush wins.
- Latency: one cycle from ID inputs to registered outputs. alu_a, alu_b and exe_st_val are combinational from the registered fields plus the forwarding inputs.
- Forwarding for operand s in {src1, src2}:
  - If mem_wb_en=1, mem_dest==s and s!=0: select mem_res.
  - Else if wb_wb_en=1, wb_dest==s and s!=0: select wb_value.
  - Else: select the registered value.
  - MEM has priority over WB. Index 0 is never forwarded.
- alu_a = fwd(src1).
- alu_b = registered imm if imm_sel=1, else fwd(src2).
- exe_st_val = fwd(src2) regardless of imm_sel.
- alu_cmd = registered cmd, passed unchanged, with legal encodings from the package. Unknown codes pass through.
- hazard_stall = exe_valid & exe_mem_r_en & (exe_dest!=0) & (exe_dest==id_src1 | exe_dest==id_src2). Combinational.
- On hazard_stall the pipeline control must assert flush on this stage for one cycle. That control is external; this block does not self-flush.
- A bubble never forwards, because its wb_en=0.

Optional Feature:
- Macro: ID_EXE_FWD_EN.
- Defined: forwarding as described above.
- Undefined: alu_a, alu_b and exe_st_val use only the registered values. hazard_stall additionally asserts on any exe_valid & exe_wb_en, or mem_wb_en, whose destination (nonzero) matches id_src1 or id_src2.

Decomposition:
- Package mips_pkg holds:
  - ALU_ADD=0000, ALU_SUB=0010, ALU_AND=0100, ALU_OR=0101, ALU_NOR=0110, ALU_XOR=0111, ALU_SLL=1000, ALU_SRA=1001, ALU_SRL=1010.
  - DW and RW defaults.
  - The forward-select enum: FWD_REG, FWD_MEM, FWD_WB.
- One sub-module, fwd_mux: per-operand source selection, instantiated twice.

Test Plan:
- Reset mid-run: drive valid traffic, pulse rst=0 asynchronously between edges -> outputs zero immediately; exe_valid=0, alu_cmd=0000.
- Capture with no hazards: id_val1=5, id_val2=7, cmd=0000, imm_sel=0 -> next cycle alu_a=5, alu_b=7, exe_valid=1.
- Double forward: src1=3, mem_dest=3 with mem_res=0xAA, wb_dest=3 with wb_value=0xBB, both wb_en=1 -> alu_a=0xAA. Repeat with src1=0 -> alu_a is the registered value.
- Load-use: exe holds a load with dest=4 and id_src2=4 -> hazard_stall=1. With src2=0 and dest=0 -> hazard_stall=0.
- Stall and flush:
  - stall=1 for 3 cycles with changing id_* -> outputs unchanged.
  - flush=1 together with stall=1 -> exe_valid=0 and wb_en=0 next cycle.
- Immediate path: imm_sel=1, id_imm=0xFFFFFFF0, src2 forwarded from MEM -> alu_b=0xFFFFFFF0 and exe_st_val=mem_res. With ID_EXE_FWD_EN undefined, the same MEM match gives hazard_stall=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: ALU command encodings, default
// datapath widths and the operand forward-select encoding.
package mips_pkg;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_NOR = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;
    localparam logic [3:0] ALU_SRL = 4'b1010;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_exe_stage_fwd_mux.sv
// Per-operand source select: the MEM result beats the WB value, which beats
// the value captured from the register file. Register 0 is never forwarded.
// When en is low the registered value is always used.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          en,
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] reg_val,
    input  logic [RW-1:0] mem_dest,
    input  logic          mem_wb_en,
    input  logic [DW-1:0] mem_res,
    input  logic [RW-1:0] wb_dest,
    input  logic          wb_wb_en,
    input  logic [DW-1:0] wb_value,
    output logic [DW-1:0] val
);

    fwd_sel_e sel;

    // Pick the youngest producer that targets this operand.
    always_comb begin
        sel = FWD_REG;
        if (en && (src != '0)) begin
            if (mem_wb_en && (mem_dest == src)) begin
                sel = FWD_MEM;
            end else if (wb_wb_en && (wb_dest == src)) begin
                sel = FWD_WB;
            end
        end
    end

    // Steer the chosen source onto the operand.
    always_comb begin
        case (sel)
            FWD_MEM: val = mem_res;
            FWD_WB:  val = wb_value;
            default: val = reg_val;
        endcase
    end

endmodule

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with ALU operand selection and load-use detection.
// Build option ID_EXE_FWD_EN: when defined, operands are forwarded from MEM/WB;
// when undefined, operands come only from the register and any in-flight
// writer of a source register raises hazard_stall instead.
module id_exe_stage
    import mips_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] id_val1,
    input  logic [DW-1:0] id_val2,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_src1,
    input  logic [RW-1:0] id_src2,
    input  logic [RW-1:0] id_dest,
    input  logic [3:0]    id_cmd,
    input  logic          id_imm_sel,
    input  logic          id_mem_r_en,
    input  logic          id_mem_w_en,
    input  logic          id_wb_en,
    input  logic [RW-1:0] mem_dest,
    input  logic          mem_wb_en,
    input  logic [DW-1:0] mem_res,
    input  logic [RW-1:0] wb_dest,
    input  logic          wb_wb_en,
    input  logic [DW-1:0] wb_value,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_cmd,
    output logic [DW-1:0] exe_st_val,
    output logic [DW-1:0] exe_pc,
    output logic [RW-1:0] exe_dest,
    output logic          exe_mem_r_en,
    output logic          exe_mem_w_en,
    output logic          exe_wb_en,
    output logic          exe_valid,
    output logic          hazard_stall
);

`ifdef ID_EXE_FWD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    logic [DW-1:0] pc_p0, val1_p0, val2_p0, imm_p0;
    logic [RW-1:0] src1_p0, src2_p0, dest_p0;
    logic [3:0]    cmd_p0;
    logic          imm_sel_p0;
    logic          vld_p0, mem_r_en_p0, mem_w_en_p0, wb_en_p0;
    logic [DW-1:0] fwd1, fwd2;
    logic          load_use;

    // ---- ID -> EXE boundary ----
    // Control fields: a flush turns the slot into a bubble that writes nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0      <= 1'b0;
            mem_r_en_p0 <= 1'b0;
            mem_w_en_p0 <= 1'b0;
            wb_en_p0    <= 1'b0;
        end else if (flush) begin
            vld_p0      <= 1'b0;
            mem_r_en_p0 <= 1'b0;
            mem_w_en_p0 <= 1'b0;
            wb_en_p0    <= 1'b0;
        end else if (!stall) begin
            vld_p0      <= 1'b1;
            mem_r_en_p0 <= id_mem_r_en;
            mem_w_en_p0 <= id_mem_w_en;
            wb_en_p0    <= id_wb_en;
        end
    end

    // Data fields: captured only on a real load; a bubble keeps stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_p0      <= '0;
            val1_p0    <= '0;
            val2_p0    <= '0;
            imm_p0     <= '0;
            src1_p0    <= '0;
            src2_p0    <= '0;
            dest_p0    <= '0;
            cmd_p0     <= ALU_ADD;
            imm_sel_p0 <= 1'b0;
        end else if (!flush && !stall) begin
            pc_p0      <= id_pc;
            val1_p0    <= id_val1;
            val2_p0    <= id_val2;
            imm_p0     <= id_imm;
            src1_p0    <= id_src1;
            src2_p0    <= id_src2;
            dest_p0    <= id_dest;
            cmd_p0     <= id_cmd;
            imm_sel_p0 <= id_imm_sel;
        end
    end

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_a (
        .en(FWD_ON), .src(src1_p0), .reg_val(val1_p0),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_res(mem_res),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .wb_value(wb_value),
        .val(fwd1)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_b (
        .en(FWD_ON), .src(src2_p0), .reg_val(val2_p0),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_res(mem_res),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .wb_value(wb_value),
        .val(fwd2)
    );

    assign alu_a        = fwd1;
    assign alu_b        = imm_sel_p0 ? imm_p0 : fwd2;
    assign exe_st_val   = fwd2;
    assign alu_cmd      = cmd_p0;
    assign exe_pc       = pc_p0;
    assign exe_dest     = dest_p0;
    assign exe_mem_r_en = mem_r_en_p0;
    assign exe_mem_w_en = mem_w_en_p0;
    assign exe_wb_en    = wb_en_p0;
    assign exe_valid    = vld_p0;

    assign load_use = vld_p0 & mem_r_en_p0 & (dest_p0 != '0) &
                      ((dest_p0 == id_src1) | (dest_p0 == id_src2));

`ifdef ID_EXE_FWD_EN
    assign hazard_stall = load_use;
`else
    // Without forwarding, any pending write to a source register must drain.
    logic exe_dep, mem_dep;
    assign exe_dep = vld_p0 & wb_en_p0 & (dest_p0 != '0) &
                     ((dest_p0 == id_src1) | (dest_p0 == id_src2));
    assign mem_dep = mem_wb_en & (mem_dest != '0) &
                     ((mem_dest == id_src1) | (mem_dest == id_src2));
    assign hazard_stall = load_use | exe_dep | mem_dep;
`endif

endmodule

// File: tb/tb_id_exe_stage.sv
// Self-checking bench for id_exe_stage: a slot-level reference model checked
// on every falling edge, plus directed vectors with literal expectations.
module tb_id_exe_stage;

    logic        clk, rst, stall, flush;
    logic [31:0] id_pc, id_val1, id_val2, id_imm;
    logic [4:0]  id_src1, id_src2, id_dest;
    logic [3:0]  id_cmd;
    logic        id_imm_sel, id_mem_r_en, id_mem_w_en, id_wb_en;
    logic [4:0]  mem_dest, wb_dest;
    logic        mem_wb_en, wb_wb_en;
    logic [31:0] mem_res, wb_value;
    logic [31:0] alu_a, alu_b, exe_st_val, exe_pc;
    logic [3:0]  alu_cmd;
    logic [4:0]  exe_dest;
    logic        exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_valid, hazard_stall;

    int errors = 0;
    int checks = 0;

`ifdef ID_EXE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    id_exe_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_pc(id_pc), .id_val1(id_val1), .id_val2(id_val2), .id_imm(id_imm),
        .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest), .id_cmd(id_cmd),
        .id_imm_sel(id_imm_sel), .id_mem_r_en(id_mem_r_en),
        .id_mem_w_en(id_mem_w_en), .id_wb_en(id_wb_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_res(mem_res),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .wb_value(wb_value),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .exe_st_val(exe_st_val),
        .exe_pc(exe_pc), .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en),
        .exe_mem_w_en(exe_mem_w_en), .exe_wb_en(exe_wb_en),
        .exe_valid(exe_valid), .hazard_stall(hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference slot: what the EXE stage currently holds.
    typedef struct {
        bit          valid, mr, mw, wb, isel;
        bit          known;      // data fields meaningful (not a flushed bubble)
        logic [31:0] pc, v1, v2, imm;
        logic [4:0]  s1, s2, d;
        logic [3:0]  cmd;
    } slot_t;

    slot_t m;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m = '{valid: 0, mr: 0, mw: 0, wb: 0, isel: 0, known: 1,
                  pc: 0, v1: 0, v2: 0, imm: 0, s1: 0, s2: 0, d: 0, cmd: 0};
        end else if (flush) begin
            m.valid = 0; m.mr = 0; m.mw = 0; m.wb = 0; m.known = 0;
        end else if (!stall) begin
            m = '{valid: 1, mr: id_mem_r_en, mw: id_mem_w_en, wb: id_wb_en,
                  isel: id_imm_sel, known: 1, pc: id_pc, v1: id_val1,
                  v2: id_val2, imm: id_imm, s1: id_src1, s2: id_src2,
                  d: id_dest, cmd: id_cmd};
        end
    end

    function automatic logic [31:0] fwd_of(input logic [4:0] s, input logic [31:0] regv);
        if (FWD && s != 0 && mem_wb_en && mem_dest == s) return mem_res;
        if (FWD && s != 0 && wb_wb_en && wb_dest == s) return wb_value;
        return regv;
    endfunction

    function automatic bit reads(input logic [4:0] r);
        return (r != 0) && (r == id_src1 || r == id_src2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        bit hz;
        hz = m.valid && m.mr && reads(m.d);
        if (!FWD) hz = hz || (m.valid && m.wb && reads(m.d)) || (mem_wb_en && reads(mem_dest));
        chk("m_valid", {31'b0, exe_valid}, {31'b0, m.valid});
        chk("m_mem_r_en", {31'b0, exe_mem_r_en}, {31'b0, m.mr});
        chk("m_mem_w_en", {31'b0, exe_mem_w_en}, {31'b0, m.mw});
        chk("m_wb_en", {31'b0, exe_wb_en}, {31'b0, m.wb});
        chk("m_hazard", {31'b0, hazard_stall}, {31'b0, hz});
        if (m.known) begin
            chk("m_alu_a", alu_a, fwd_of(m.s1, m.v1));
            chk("m_alu_b", alu_b, m.isel ? m.imm : fwd_of(m.s2, m.v2));
            chk("m_st_val", exe_st_val, fwd_of(m.s2, m.v2));
            chk("m_alu_cmd", {28'b0, alu_cmd}, {28'b0, m.cmd});
            chk("m_pc", exe_pc, m.pc);
            chk("m_dest", {27'b0, exe_dest}, {27'b0, m.d});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic [31:0] pc, v1, v2, imm,
                          input logic [4:0] s1, s2, d, input logic [3:0] cmd,
                          input logic isel, mr, mw, wb);
        id_pc = pc; id_val1 = v1; id_val2 = v2; id_imm = imm;
        id_src1 = s1; id_src2 = s2; id_dest = d; id_cmd = cmd;
        id_imm_sel = isel; id_mem_r_en = mr; id_mem_w_en = mw; id_wb_en = wb;
    endtask

    task automatic no_fwd();
        mem_dest = 0; mem_wb_en = 0; mem_res = 0;
        wb_dest = 0; wb_wb_en = 0; wb_value = 0;
    endtask

    initial begin
        rst = 0; stall = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        no_fwd();
        step(); step();
        chk("reset_valid", {31'b0, exe_valid}, 0);
        chk("reset_cmd", {28'b0, alu_cmd}, 0);
        rst = 1;

        // Plain capture
        set_id(32'h100, 5, 7, 0, 1, 2, 3, 4'b0000, 0, 0, 0, 1);
        step(); #1;
        chk("cap_alu_a", alu_a, 5);
        chk("cap_alu_b", alu_b, 7);
        chk("cap_valid", {31'b0, exe_valid}, 1);
        chk("cap_hazard", {31'b0, hazard_stall}, 0);

        // Double forward on src1 = 3: MEM beats WB
        set_id(32'h104, 32'h11, 32'h22, 0, 3, 5, 6, 4'b0010, 0, 0, 0, 1);
        mem_dest = 3; mem_wb_en = 1; mem_res = 32'hAA;
        wb_dest = 3; wb_wb_en = 1; wb_value = 32'hBB;
        step(); #1;
        chk("dbl_fwd_a", alu_a, FWD ? 32'hAA : 32'h11);
        chk("dbl_fwd_cmd", {28'b0, alu_cmd}, 4'b0010);
        chk("dbl_fwd_hz", {31'b0, hazard_stall}, FWD ? 0 : 1);
        // src1 = 0 never forwards
        set_id(32'h108, 32'h33, 32'h44, 0, 0, 5, 7, 4'b0100, 0, 0, 0, 1);
        mem_dest = 0; wb_dest = 0;
        step(); #1;
        chk("zero_src_a", alu_a, 32'h33);
        no_fwd();

        // Load-use
        set_id(32'h10c, 32'h40, 32'h50, 0, 1, 2, 4, 4'b0000, 0, 1, 0, 1);
        step();
        id_src1 = 9; id_src2 = 4; #1;
        chk("load_use_hz", {31'b0, hazard_stall}, 1);
        set_id(32'h110, 32'h40, 32'h50, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 1);
        step(); #1;
        chk("load_dest0_hz", {31'b0, hazard_stall}, 0);

        // Stall for three cycles with changing ID inputs
        set_id(32'h200, 32'h1234, 32'h5678, 0, 1, 2, 8, 4'b0101, 0, 0, 0, 1);
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(32'h300 + i, 32'h9000 + i, 32'hA000 + i, 32'h1, 5'd10 + 5'(i),
                   5'd11, 5'd12, 4'b0111, 1, 1, 1, 0);
            step(); #1;
            chk("stall_pc", exe_pc, 32'h200);
            chk("stall_alu_a", alu_a, 32'h1234);
            chk("stall_dest", {27'b0, exe_dest}, 8);
        end
        flush = 1;
        step(); #1;
        chk("flush_valid", {31'b0, exe_valid}, 0);
        chk("flush_wb_en", {31'b0, exe_wb_en}, 0);
        flush = 0; stall = 0;

        // Immediate path with src2 matching MEM
        set_id(32'h400, 1, 2, 32'hFFFFFFF0, 1, 5, 9, 4'b0000, 1, 0, 1, 0);
        step();
        mem_dest = 5; mem_wb_en = 1; mem_res = 32'hCAFE; #1;
        chk("imm_alu_b", alu_b, 32'hFFFFFFF0);
        chk("imm_st_val", exe_st_val, FWD ? 32'hCAFE : 32'h2);
        chk("imm_hz", {31'b0, hazard_stall}, FWD ? 0 : 1);
        no_fwd();

        // Asynchronous reset between edges
        set_id(32'h500, 32'h77, 32'h88, 0, 1, 2, 3, 4'b1001, 0, 0, 0, 1);
        step(); #1;
        rst = 0; #1;
        chk("async_valid", {31'b0, exe_valid}, 0);
        chk("async_cmd", {28'b0, alu_cmd}, 0);
        chk("async_alu_a", alu_a, 0);
        chk("async_alu_b", alu_b, 0);
        chk("async_hz", {31'b0, hazard_stall}, 0);
        step();
        rst = 1;

        // Mixed traffic checked by the model
        for (int i = 0; i < 40; i++) begin
            set_id($urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 5)),
                   5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                   4'($urandom_range(0, 10)), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
            mem_dest = 5'($urandom_range(0, 5)); mem_wb_en = 1'($urandom); mem_res = $urandom;
            wb_dest = 5'($urandom_range(0, 5)); wb_wb_en = 1'($urandom); wb_value = $urandom;
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 5) == 0);
            step();
        end
        stall = 0; flush = 0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
